// File: rtl/ram_sdp_byte_en.sv
`default_nettype none
// ============================================================================
// Module      : ram_sdp_byte_en
// Description : Simple-dual-port RAM with a byte-enabled write port and one
//               read port. The read port is either asynchronous or registered
//               (latency 1, write-first or read-first on address collision).
//               An optional clear sequencer writes INIT_VALUE to every word
//               after reset, holding init_busy high while it runs.
// Ports       : clk       - sole clock, rising edge
//               rst       - synchronous active-high reset
//               wr_en     - write request
//               wr_addr   - write address
//               wr_data   - write data
//               wr_be     - byte-lane enables (lane i = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH])
//               rd_en     - read request
//               rd_addr   - read address
//               rd_data   - read data
//               rd_valid  - rd_data holds the result of an accepted read
//               init_busy - clear sequencer active (or rst high); requests ignored
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sdp_byte_en #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    READ_REG    = 0,
    parameter int                    WRITE_FIRST = 1,
    parameter int                    INIT_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             init_busy
);

    localparam int                    c_DEPTH     = 1 << ADDR_WIDTH;
    localparam int                    c_NUM_BE    = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_DEPTH - 1);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;
    localparam logic [0:0] c_ST_RESET = (INIT_ON_RST != 0) ? c_ST_CLEAR : c_ST_READY;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_clr_we;
    logic                  w_ready;
    logic                  w_wr_we;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_word;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // ------------------------------------------------------------------
    // Clear sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            c_ST_CLEAR: begin
                w_clr_we = ~rst;
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_state_nxt = c_ST_READY;
                end
            end
            c_ST_READY: begin
                w_ready = ~rst;
            end
            default: begin
                w_state_nxt = c_ST_RESET;
            end
        endcase
    end

    // Counter saturates at the last address; the FSM leaves CLEAR on that
    // same edge, so it never needs to wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_clr_we && (r_clr_cnt != c_LAST_ADDR)) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign init_busy = rst | (r_state == c_ST_CLEAR);

    // ------------------------------------------------------------------
    // Write path: merge enabled lanes into the current word. The merged
    // word is also the write-first bypass value for the registered read.
    // ------------------------------------------------------------------
    assign w_wr_we  = w_ready & wr_en;
    assign w_wr_old = r_mem[wr_addr];

    for (genvar gi = 0; gi < c_NUM_BE; gi++) begin : g_lane
        assign w_wr_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            wr_be[gi] ? wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
                      : w_wr_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // Storage carries no reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= INIT_VALUE;
        end else if (w_wr_we) begin
            r_mem[wr_addr] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    if (READ_REG != 0) begin : g_rd_reg
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_valid;
        logic                  w_bypass;

        assign w_bypass = (WRITE_FIRST != 0) && w_wr_we && (wr_addr == rd_addr);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else if (rd_en && w_ready) begin
                r_rd_data  <= w_bypass ? w_wr_word : r_mem[rd_addr];
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end else begin : g_rd_async
        assign rd_data  = r_mem[rd_addr];
        assign rd_valid = rd_en & ~init_busy;
    end

endmodule
`default_nettype wire
